// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, port IDs and defaults for the memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  localparam logic PORT_PIPE = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int DEF_TIMEOUT = 15;
  localparam int CNT_W = 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports, stall/error and data-memory bus of the arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic p0_req_i, p0_we_i, p0_ack_o;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_wdata_i, p0_rdata_o;
  logic p1_req_i, p1_we_i, p1_ack_o;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_wdata_i, p1_rdata_o;
  logic stall_o, err_o, err_port_o;
  logic mem_req_o, mem_we_o, mem_ack_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
  modport slave (
    input p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i, p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    input mem_rdata_i, mem_ack_i,
    output p0_ack_o, p0_rdata_o, p1_ack_o, p1_rdata_o, stall_o, err_o, err_port_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i, p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input p0_ack_o, p0_rdata_o, p1_ack_o, p1_rdata_o, stall_o, err_o, err_port_o,
    input mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter_timeout_cnt.sv
// arb_timeout_cnt: 8-bit access-cycle counter; expire_o flags the last allowed cycle.
module arb_timeout_cnt import mem_arbiter_pkg::*; #(parameter int LIMIT = DEF_TIMEOUT) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  // Flag the cycle whose missing ack would make the count reach LIMIT.
  assign expire_o = cnt_q == CNT_W'(LIMIT - 1);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of pipeline and debug ports onto one data memory,
// with per-access timeout abort.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk_i,
  input logic reset_n_i,
  mem_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic grant_q, grant_d, ptr_q, ptr_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d, rdata_fin;
  logic win, in_access, expire, p0_ack;
  assign in_access = state_q == ACCESS;
  // On a tie the port granted last loses; a single requester always wins.
  assign win = (bus.p0_req_i & bus.p1_req_i) ? ~ptr_q : bus.p1_req_i;
  assign rdata_fin = bus.mem_ack_i ? bus.mem_rdata_i : '0;
  arb_timeout_cnt #(.LIMIT(TIMEOUT)) u_cnt (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .clr_i(!in_access),
    .en_i(in_access & !bus.mem_ack_i),
    .expire_o(expire)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: if (bus.p0_req_i | bus.p1_req_i) begin
        state_d = ACCESS;
        grant_d = win;
        ptr_d = win;
        we_d = win ? bus.p1_we_i : bus.p0_we_i;
        addr_d = win ? bus.p1_addr_i : bus.p0_addr_i;
        wdata_d = win ? bus.p1_wdata_i : bus.p0_wdata_i;
        err_d = 1'b0;
      end
      ACCESS: if (bus.mem_ack_i | expire) begin
        state_d = DONE;
        err_d = !bus.mem_ack_i;
        rdata0_d = (!we_q && grant_q == PORT_PIPE) ? rdata_fin : rdata0_q;
        rdata1_d = (!we_q && grant_q == PORT_DBG) ? rdata_fin : rdata1_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= IDLE;
      grant_q <= PORT_PIPE;
      ptr_q <= PORT_DBG;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  assign p0_ack = state_q == DONE && grant_q == PORT_PIPE;
  assign bus.p0_ack_o = p0_ack;
  assign bus.p1_ack_o = state_q == DONE && grant_q == PORT_DBG;
  assign bus.p0_rdata_o = rdata0_q;
  assign bus.p1_rdata_o = rdata1_q;
  assign bus.err_o = state_q == DONE && err_q;
  assign bus.err_port_o = state_q == DONE && err_q && grant_q;
  assign bus.stall_o = bus.p0_req_i & ~p0_ack;
  assign bus.mem_req_o = in_access;
  assign bus.mem_we_o = in_access & we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with TIMEOUT=4.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ntests = 0;
  int nfail = 0;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.p0_req_i = 0; bus.p0_we_i = 0; bus.p0_addr_i = 0; bus.p0_wdata_i = 0;
    bus.p1_req_i = 0; bus.p1_we_i = 0; bus.p1_addr_i = 0; bus.p1_wdata_i = 0;
    bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
    #1;
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_p0_ack", bus.p0_ack_o, 0);
    chk("rst_p1_ack", bus.p1_ack_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_p0_rdata", bus.p0_rdata_o, 0);
    chk("rst_p1_rdata", bus.p1_rdata_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    step(); step();
    rst_n = 1;
    // Round-robin: both ports request twice, loads with ack in first ACCESS cycle.
    bus.p0_addr_i = 32'h10; bus.p1_addr_i = 32'h20;
    bus.p0_req_i = 1; bus.p1_req_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_idle_mem_req", bus.mem_req_o, 0);
      step();
      chk("rr_access_addr", bus.mem_addr_o, (k % 2) ? 32'h20 : 32'h10);
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h1000 + k;
      step();
      bus.mem_ack_i = 0;
      chk("rr_p0_ack", bus.p0_ack_o, (k % 2) ? 0 : 1);
      chk("rr_p1_ack", bus.p1_ack_o, (k % 2) ? 1 : 0);
      if (k == 2) bus.p0_req_i = 0;
      if (k == 3) bus.p1_req_i = 0;
      step();
    end
    chk("rr_p0_rdata", bus.p0_rdata_o, 32'h1002);
    chk("rr_p1_rdata", bus.p1_rdata_o, 32'h1003);
    // Minimum-latency p0 load.
    bus.p0_req_i = 1; bus.p0_we_i = 0; bus.p0_addr_i = 32'h40;
    #1;
    chk("lat_stall_c0", bus.stall_o, 1);
    step();
    chk("lat_mem_req_c1", bus.mem_req_o, 1);
    chk("lat_addr_c1", bus.mem_addr_o, 32'h40);
    chk("lat_we_c1", bus.mem_we_o, 0);
    chk("lat_stall_c1", bus.stall_o, 1);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hDEADBEEF;
    step();
    bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
    chk("lat_p0_ack_c2", bus.p0_ack_o, 1);
    chk("lat_p0_rdata_c2", bus.p0_rdata_o, 32'hDEADBEEF);
    chk("lat_stall_c2", bus.stall_o, 0);
    chk("lat_mem_req_c2", bus.mem_req_o, 0);
    bus.p0_req_i = 0;
    step();
    chk("lat_p0_ack_c3", bus.p0_ack_o, 0);
    // p1 store with ack in the third ACCESS cycle.
    bus.p1_req_i = 1; bus.p1_we_i = 1; bus.p1_addr_i = 32'h100; bus.p1_wdata_i = 32'h5A5A5A5A;
    step();
    bus.p1_addr_i = 32'h0; bus.p1_wdata_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      chk("st_mem_req", bus.mem_req_o, 1);
      chk("st_mem_we", bus.mem_we_o, 1);
      chk("st_addr", bus.mem_addr_o, 32'h100);
      chk("st_wdata", bus.mem_wdata_o, 32'h5A5A5A5A);
      chk("st_p1_ack_early", bus.p1_ack_o, 0);
      if (c == 2) begin bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h12345678; end
      step();
    end
    bus.mem_ack_i = 0;
    chk("st_p1_ack", bus.p1_ack_o, 1);
    chk("st_p0_ack", bus.p0_ack_o, 0);
    chk("st_mem_we_done", bus.mem_we_o, 0);
    chk("st_p0_rdata_hold", bus.p0_rdata_o, 32'hDEADBEEF);
    chk("st_p1_rdata_hold", bus.p1_rdata_o, 32'h1003);
    bus.p1_req_i = 0; bus.p1_we_i = 0;
    step();
    chk("st_p1_ack_once", bus.p1_ack_o, 0);
    // p0 load times out after 4 ACCESS cycles.
    bus.p0_req_i = 1; bus.p0_addr_i = 32'h80;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("to_mem_req", bus.mem_req_o, 1);
      chk("to_err_early", bus.err_o, 0);
      step();
    end
    chk("to_p0_ack", bus.p0_ack_o, 1);
    chk("to_err", bus.err_o, 1);
    chk("to_err_port", bus.err_port_o, 0);
    chk("to_p0_rdata", bus.p0_rdata_o, 0);
    chk("to_mem_req_done", bus.mem_req_o, 0);
    bus.p0_req_i = 0;
    step();
    chk("to_err_pulse", bus.err_o, 0);
    bus.p0_req_i = 1; bus.p0_addr_i = 32'h84;
    step();
    chk("to_next_addr", bus.mem_addr_o, 32'h84);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hCAFEF00D;
    step();
    bus.mem_ack_i = 0;
    chk("to_next_ack", bus.p0_ack_o, 1);
    chk("to_next_err", bus.err_o, 0);
    chk("to_next_rdata", bus.p0_rdata_o, 32'hCAFEF00D);
    bus.p0_req_i = 0;
    step();
    // p1 load acked in the final allowed cycle: success, no error.
    bus.p1_req_i = 1; bus.p1_addr_i = 32'h24;
    step();
    step(); step(); step();
    chk("edge_still_access", bus.mem_req_o, 1);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hA5A50004;
    step();
    bus.mem_ack_i = 0;
    chk("edge_p1_ack", bus.p1_ack_o, 1);
    chk("edge_err", bus.err_o, 0);
    chk("edge_p1_rdata", bus.p1_rdata_o, 32'hA5A50004);
    bus.p1_req_i = 0;
    step();
    // p1 store timeout reports port 1 and leaves its load data alone.
    bus.p1_req_i = 1; bus.p1_we_i = 1; bus.p1_addr_i = 32'h2C;
    step();
    step(); step(); step(); step();
    chk("to1_err", bus.err_o, 1);
    chk("to1_err_port", bus.err_port_o, 1);
    chk("to1_p1_ack", bus.p1_ack_o, 1);
    chk("to1_p1_rdata", bus.p1_rdata_o, 32'hA5A50004);
    bus.p1_req_i = 0; bus.p1_we_i = 0;
    step();
    // Reset during a p1 ACCESS aborts silently.
    bus.p1_req_i = 1; bus.p1_addr_i = 32'h28;
    step();
    chk("rs_mem_req_before", bus.mem_req_o, 1);
    rst_n = 0;
    #1;
    chk("rs_mem_req_async", bus.mem_req_o, 0);
    chk("rs_p1_ack", bus.p1_ack_o, 0);
    chk("rs_err", bus.err_o, 0);
    chk("rs_p0_rdata", bus.p0_rdata_o, 0);
    chk("rs_p1_rdata", bus.p1_rdata_o, 0);
    step(); step();
    chk("rs_p1_ack_hold", bus.p1_ack_o, 0);
    chk("rs_err_hold", bus.err_o, 0);
    chk("rs_mem_req_hold", bus.mem_req_o, 0);
    rst_n = 1;
    bus.p0_req_i = 1; bus.p0_addr_i = 32'h30;
    step();
    chk("rs_tie_p0", bus.mem_addr_o, 32'h30);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h00000030;
    step();
    bus.mem_ack_i = 0;
    chk("rs_p0_ack", bus.p0_ack_o, 1);
    chk("rs_p1_ack_tie", bus.p1_ack_o, 0);
    bus.p0_req_i = 0;
    step();
    step();
    chk("rs_then_p1", bus.mem_addr_o, 32'h28);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h00000028;
    step();
    bus.mem_ack_i = 0;
    chk("rs_p1_ack_final", bus.p1_ack_o, 1);
    chk("rs_p1_rdata_final", bus.p1_rdata_o, 32'h28);
    bus.p1_req_i = 0;
    step();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
